// File: rtl/operand_load_ctrl.sv
// Operand load controller: captures operand A, then operand B, from one shared
// data bus on successive Load presses and registers their (N+1)-bit sum.
// Load is a raw push-button level; it is synchronised and edge-detected here.
module operand_load_ctrl #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Load,
  input  logic         Clear,
  input  logic [N-1:0] Data,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N:0]   Sum,
  output logic         LdA,
  output logic         LdB,
  output logic [1:0]   State,
  output logic         Done
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    RESULT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  logic         s1_r;
  logic         s2_r;
  logic         s3_r;
  logic         press_s;

  state_t       state_r;
  state_t       state_next_s;
  logic [N-1:0] a_r;
  logic [N-1:0] a_next_s;
  logic [N-1:0] b_r;
  logic [N-1:0] b_next_s;
  logic [N:0]   sum_r;
  logic [N:0]   sum_next_s;
  logic         lda_r;
  logic         lda_next_s;
  logic         ldb_r;
  logic         ldb_next_s;
  logic         done_r;
  logic         done_next_s;

  // Two-flop synchroniser plus delay flop; deliberately not touched by Clear
  // so a button held through Clear cannot produce a second press.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= Load;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // One-cycle pulse on each synchronised rising edge of Load.
  assign press_s = s2_r & ~s3_r;

  // Next-state and next-register values; Clear outranks any press.
  always_comb begin
    state_next_s = state_r;
    a_next_s     = a_r;
    b_next_s     = b_r;
    sum_next_s   = sum_r;
    lda_next_s   = 1'b0;
    ldb_next_s   = 1'b0;
    if (Clear) begin
      state_next_s = WAIT_A;
      a_next_s     = {N{1'b0}};
      b_next_s     = {N{1'b0}};
      sum_next_s   = {(N+1){1'b0}};
    end else begin
      case (state_r)
        WAIT_A: begin
          if (press_s) begin
            a_next_s     = Data;
            lda_next_s   = 1'b1;
            state_next_s = WAIT_B;
          end else begin
            state_next_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (press_s) begin
            b_next_s     = Data;
            sum_next_s   = {1'b0, a_r} + {1'b0, Data};
            ldb_next_s   = 1'b1;
            state_next_s = RESULT;
          end else begin
            state_next_s = WAIT_B;
          end
        end
        RESULT: begin
          if (press_s) begin
            // A press after a result starts a fresh pair.
            a_next_s     = Data;
            b_next_s     = {N{1'b0}};
            sum_next_s   = {(N+1){1'b0}};
            lda_next_s   = 1'b1;
            state_next_s = WAIT_B;
          end else begin
            state_next_s = RESULT;
          end
        end
        default: begin
          // Unreachable code 11: recover to a clean initial state.
          state_next_s = WAIT_A;
          a_next_s     = {N{1'b0}};
          b_next_s     = {N{1'b0}};
          sum_next_s   = {(N+1){1'b0}};
        end
      endcase
    end
    done_next_s = (state_next_s == RESULT);
  end

  // State, operand, sum and strobe registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= WAIT_A;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      sum_r   <= {(N+1){1'b0}};
      lda_r   <= 1'b0;
      ldb_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      a_r     <= a_next_s;
      b_r     <= b_next_s;
      sum_r   <= sum_next_s;
      lda_r   <= lda_next_s;
      ldb_r   <= ldb_next_s;
      done_r  <= done_next_s;
    end
  end

  assign A     = a_r;
  assign B     = b_r;
  assign Sum   = sum_r;
  assign LdA   = lda_r;
  assign LdB   = ldb_r;
  assign State = state_r;
  assign Done  = done_r;

endmodule

// File: doc/operand_load_ctrl.md
Name: operand_load_ctrl

Overview:
Sequencer that captures two N-bit operands, A and B, one after the other from a single shared data bus, using one Load push-button. It forms the registered sum of the two operands. It sits between the board switches/keys and the HEX display decoders: the top level drives Data from SW and Load from an inverted KEY, and feeds A, B and Sum to hex7seg digits. It replaces hand-wired single-register capture when more than one operand shares the switches.

Parameters:
N, 8, operand width in bits; Data, A and B are N bits wide, Sum is N+1 bits wide.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Resetn  input  1  asynchronous, active-low reset.
Load  input  1  active-high load request, asynchronous to Clock (push-button level).
Clear  input  1  synchronous, active-high return to initial state; already synchronous to Clock.
Data  input  N  shared operand bus (switches).
A  output  N  registered operand A.
B  output  N  registered operand B.
Sum  output  N+1  registered A+B, including carry-out in bit N.
LdA  output  1  one-cycle strobe on the edge after A is written.
LdB  output  1  one-cycle strobe on the edge after B is written.
State  output  2  current state encoding, for debug LEDs.
Done  output  1  high while in RESULT.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State=WAIT_A (2'b00).
  - A, B, Sum, LdA, LdB, Done = 0.
  - Synchronizer and edge flops s1, s2, s3 = 0.
- Load conditioning:
  - Two-flop synchronizer: s1<=Load, s2<=s1.
  - Delay flop: s3<=s2.
  - press = s2 & ~s3, a combinational one-cycle pulse.
  - A Load that is first sampled high at edge k produces its action at edge k+2.
  - One action per rising transition of Load; holding Load high never repeats.
  - Because the flops reset to 0, a Load already high when Resetn releases counts as one press.
- State encoding: WAIT_A=00, WAIT_B=01, RESULT=10. Code 11 is illegal and recovers to WAIT_A on the next edge, with all registers zeroed.
- Transitions and actions, on press:
  - WAIT_A: A<=Data; LdA=1 for 1 cycle; go to WAIT_B.
  - WAIT_B: B<=Data; Sum<=A+Data (zero-extended to N+1 bits, so carry lands in bit N); LdB=1 for 1 cycle; go to RESULT.
  - RESULT: A<=Data; B<=0; Sum<=0; LdA=1 for 1 cycle; go to WAIT_B. This starts a new pair.
- With no press: state and registers hold. LdA and LdB return to 0.
- Done = (State==RESULT). It is registered together with the state.
- Sum is valid whenever Done=1. Sum is never updated outside the WAIT_B->RESULT transition, except by clear, reset or RESULT->WAIT_B.
- Clear=1 at an edge:
  - State=WAIT_A; A, B, Sum = 0; LdA, LdB = 0.
  - Any coincident press is discarded.
  - The synchronizer keeps running, so a Load held through Clear does not generate a second press.
- Data is sampled only at the action edge. Data changes at any other time have no effect.
- Reset asserted mid-sequence (e.g., in WAIT_B) aborts immediately. The stored A is lost.

Test Plan:
- Reset then idle: Resetn=0 for 2 cycles, then release with Load=0 -> State=00; A=B=Sum=0; Done=0; no strobes for 20 cycles.
- Basic pair:
  - Data=8'h3C, pulse Load for 1 cycle -> A=3C at edge k+2 and LdA high 1 cycle; State=01.
  - Then Data=8'h15, pulse Load -> B=15, Sum=9'h051, LdB high 1 cycle, Done=1, State=10.
- Carry: A=8'hFF, B=8'h01 -> Sum=9'h100. Also A=8'hFF, B=8'hFF -> Sum=9'h1FE.
- Held button: Load held high for 50 cycles in WAIT_A with Data=8'h0A -> exactly one LdA, A=0A, State=01, B unchanged.
- Restart from RESULT: after Sum=051, Data=8'h77 with a Load press -> A=77, B=0, Sum=0, Done=0, State=01.
- Clear/reset priority:
  - Clear asserted on the same edge as a press in WAIT_B -> State=00, all registers 0, no LdB.
  - Resetn pulsed low mid-cycle in WAIT_B -> outputs 0 immediately, asynchronously, without waiting for a Clock edge.
